// File: rtl/tetromino_pkg.sv
// rtl/tetromino_pkg.sv - shared types and constants for the tetromino game-sequencing core
package tetromino_pkg;

  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 23;
  localparam int VISIBLE_H = 20;
  localparam int X_W       = 4;
  localparam int Y_W       = 5;

  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;
  localparam logic [2:0] PIECE_T = 3'd2;
  localparam logic [2:0] PIECE_S = 3'd3;
  localparam logic [2:0] PIECE_Z = 3'd4;
  localparam logic [2:0] PIECE_J = 3'd5;
  localparam logic [2:0] PIECE_L = 3'd6;

  localparam logic [2:0] MAX_LINES = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FALL,
    ST_LOCK,
    ST_CHECK,
    ST_CLEAR,
    ST_SETTLE,
    ST_SCORE,
    ST_GAMEOVER
  } state_t;

endpackage

// File: rtl/piece_decoder.sv
// rtl/piece_decoder.sv - combinational shape ROM: piece anchor, type and rotation to four cells
// Coordinates wrap modulo 2^width; the consumer flags x >= 10 or y >= 23 as out of bounds.
module piece_decoder
  import tetromino_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [2:0]     block_type,
  input  logic [1:0]     rotation,
  output logic [X_W-1:0] x1,
  output logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x2,
  output logic [Y_W-1:0] y2,
  output logic [X_W-1:0] x3,
  output logic [Y_W-1:0] y3,
  output logic [X_W-1:0] x4,
  output logic [Y_W-1:0] y4
);

  // offsets of cells 2..4 relative to the anchor (cell 1)
  logic signed [2:0] dx [3];
  logic signed [2:0] dy [3];
  logic [1:0]        rot;

  always_comb begin
    logic signed [2:0] tmp;
    tmp = '0;
    dx  = '{3'sd0, 3'sd0, 3'sd0};
    dy  = '{3'sd0, 3'sd0, 3'sd0};
    case (block_type)
      PIECE_O: begin dx = '{ 3'sd1,  3'sd0,  3'sd1}; dy = '{ 3'sd0, -3'sd1, -3'sd1}; end
      PIECE_T: begin dx = '{-3'sd1,  3'sd1,  3'sd0}; dy = '{ 3'sd0,  3'sd0,  3'sd1}; end
      PIECE_S: begin dx = '{-3'sd1,  3'sd0,  3'sd1}; dy = '{ 3'sd0,  3'sd1,  3'sd1}; end
      PIECE_Z: begin dx = '{ 3'sd1,  3'sd0, -3'sd1}; dy = '{ 3'sd0,  3'sd1,  3'sd1}; end
      PIECE_J: begin dx = '{-3'sd1,  3'sd1, -3'sd1}; dy = '{ 3'sd0,  3'sd0,  3'sd1}; end
      PIECE_L: begin dx = '{-3'sd1,  3'sd1,  3'sd1}; dy = '{ 3'sd0,  3'sd0,  3'sd1}; end
      default: begin dx = '{-3'sd1,  3'sd1,  3'sd2}; dy = '{ 3'sd0,  3'sd0,  3'sd0}; end
    endcase

    rot = (block_type == PIECE_O) ? 2'd0 : rotation;
    // each clockwise quarter turn maps (dx, dy) to (dy, -dx)
    for (int s = 0; s < 3; s++) begin
      if (s < int'(rot)) begin
        for (int c = 0; c < 3; c++) begin
          tmp   = dx[c];
          dx[c] = dy[c];
          dy[c] = -tmp;
        end
      end
    end
  end

  assign x1 = x;
  assign y1 = y;
  assign x2 = x + {dx[0][2], dx[0]};
  assign y2 = y + {{2{dy[0][2]}}, dy[0]};
  assign x3 = x + {dx[1][2], dx[1]};
  assign y3 = y + {{2{dy[1][2]}}, dy[1]};
  assign x4 = x + {dx[2][2], dx[2]};
  assign y4 = y + {{2{dy[2][2]}}, dy[2]};

endmodule

// File: rtl/tetromino_ctrl.sv
// rtl/tetromino_ctrl.sv - Tetris game state machine, shape decoder and completed-row encoder
// Optional TETROMINO_RESTART_EN: start_game in GAMEOVER returns to IDLE.
module tetromino_ctrl
  import tetromino_pkg::*;
(
  input  logic           clock_framerate,
  input  logic           resetn,
  input  logic           fall_tick,
  input  logic           start_game,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [2:0]     block_type,
  input  logic [1:0]     rotation,
  input  logic           filled_under,
  input  logic           overflow,
  input  logic [19:0]    completed_lines,
  output logic [X_W-1:0] x1,
  output logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x2,
  output logic [Y_W-1:0] y2,
  output logic [X_W-1:0] x3,
  output logic [Y_W-1:0] y3,
  output logic [X_W-1:0] x4,
  output logic [Y_W-1:0] y4,
  output logic [4:0]     cleared_index,
  output logic           load_block,
  output logic           drop_block,
  output logic           update_board_state,
  output logic           shift_down,
  output logic           add_score,
  output logic [2:0]     score_multiplier,
  output logic           game_over
);

  state_t     state, state_next;
  logic [2:0] line_count, line_count_next;

  piece_decoder u_piece_decoder (
    .x          (x),
    .y          (y),
    .block_type (block_type),
    .rotation   (rotation),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .x3         (x3),
    .y3         (y3),
    .x4         (x4),
    .y4         (y4)
  );

  // scan top-down so the lowest full row is the last one written
  always_comb begin
    cleared_index = 5'd31;
    for (int r = VISIBLE_H - 1; r >= 0; r--) begin
      if (completed_lines[r]) cleared_index = 5'(r);
    end
  end

  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      line_count <= 3'd0;
    end else begin
      state      <= state_next;
      line_count <= line_count_next;
    end
  end

  always_comb begin
    state_next         = state;
    line_count_next    = line_count;
    load_block         = 1'b0;
    drop_block         = 1'b0;
    update_board_state = 1'b0;
    shift_down         = 1'b0;
    add_score          = 1'b0;
    score_multiplier   = 3'd0;
    game_over          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_game) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_block = 1'b1;
        if (fall_tick) state_next = ST_FALL;
      end
      ST_FALL: begin
        drop_block = 1'b1;
        if (fall_tick && filled_under) state_next = ST_LOCK;
      end
      ST_LOCK: begin
        update_board_state = 1'b1;
        if (fall_tick) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (overflow) begin
          state_next = ST_GAMEOVER;
        end else if (|completed_lines) begin
          state_next      = ST_CLEAR;
          line_count_next = 3'd0;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        shift_down = 1'b1;
        if (line_count < MAX_LINES) line_count_next = line_count + 3'd1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        // board has shifted by now; loop while rows remain full
        state_next = (|completed_lines) ? ST_CLEAR : ST_SCORE;
      end
      ST_SCORE: begin
        add_score        = 1'b1;
        score_multiplier = line_count;
        state_next       = ST_LOAD;
      end
      ST_GAMEOVER: begin
        game_over = 1'b1;
`ifdef TETROMINO_RESTART_EN
        if (start_game) begin
          state_next      = ST_IDLE;
          line_count_next = 3'd0;
        end
`else
        state_next = ST_GAMEOVER;
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tetromino_ctrl.sv
// tb/tb_tetromino_ctrl.sv - randomized self-checking bench for tetromino_ctrl
module tb_tetromino_ctrl;

  logic        clock_framerate = 1'b0;
  logic        resetn = 1'b0;
  logic        fall_tick = 1'b0;
  logic        start_game = 1'b0;
  logic [3:0]  x = '0;
  logic [4:0]  y = '0;
  logic [2:0]  block_type = '0;
  logic [1:0]  rotation = '0;
  logic        filled_under = 1'b0;
  logic        overflow = 1'b0;
  logic [19:0] completed_lines = '0;
  logic [3:0]  x1, x2, x3, x4;
  logic [4:0]  y1, y2, y3, y4;
  logic [4:0]  cleared_index;
  logic        load_block, drop_block, update_board_state, shift_down, add_score, game_over;
  logic [2:0]  score_multiplier;

  int checks = 0;
  int failures = 0;

  localparam logic [8:0] V_ZERO  = 9'h000;
  localparam logic [8:0] V_LOAD  = 9'h100;
  localparam logic [8:0] V_DROP  = 9'h080;
  localparam logic [8:0] V_LOCK  = 9'h040;
  localparam logic [8:0] V_SHIFT = 9'h020;
  localparam logic [8:0] V_OVER  = 9'h001;

  logic [8:0]  outs;
  logic [35:0] cells;
  assign outs  = {load_block, drop_block, update_board_state, shift_down, add_score,
                  score_multiplier, game_over};
  assign cells = {x1, y1, x2, y2, x3, y3, x4, y4};

  // rotation-0 offsets per piece type I,O,T,S,Z,J,L
  int ox [0:6][0:3] = '{'{0,-1,1,2}, '{0,1,0,1}, '{0,-1,1,0}, '{0,-1,0,1},
                        '{0,1,0,-1}, '{0,-1,1,-1}, '{0,-1,1,1}};
  int oy [0:6][0:3] = '{'{0,0,0,0}, '{0,0,-1,-1}, '{0,0,0,1}, '{0,0,1,1},
                        '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}};

  tetromino_ctrl dut (
    .clock_framerate    (clock_framerate),
    .resetn             (resetn),
    .fall_tick          (fall_tick),
    .start_game         (start_game),
    .x                  (x),
    .y                  (y),
    .block_type         (block_type),
    .rotation           (rotation),
    .filled_under       (filled_under),
    .overflow           (overflow),
    .completed_lines    (completed_lines),
    .x1                 (x1),
    .y1                 (y1),
    .x2                 (x2),
    .y2                 (y2),
    .x3                 (x3),
    .y3                 (y3),
    .x4                 (x4),
    .y4                 (y4),
    .cleared_index      (cleared_index),
    .load_block         (load_block),
    .drop_block         (drop_block),
    .update_board_state (update_board_state),
    .shift_down         (shift_down),
    .add_score          (add_score),
    .score_multiplier   (score_multiplier),
    .game_over          (game_over)
  );

  always #5 clock_framerate = ~clock_framerate;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [35:0] ref_cells(int px, int py, int bt, int rot);
    int t, k, dx, dy, tmp;
    logic [35:0] r;
    t = (bt == 7) ? 0 : bt;
    k = (t == 1) ? 0 : rot;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      dx = ox[t][c];
      dy = oy[t][c];
      for (int s = 0; s < k; s++) begin
        tmp = dx;
        dx  = dy;
        dy  = -tmp;
      end
      r[35-9*c -: 4] = 4'((px + dx) & 15);
      r[31-9*c -: 5] = 5'((py + dy) & 31);
    end
    return r;
  endfunction

  function automatic int ref_lowest(logic [19:0] lines);
    int e;
    e = 31;
    for (int r = 0; r < 20; r++) if (lines[r] && e == 31) e = r;
    return e;
  endfunction

  task automatic step();
    @(posedge clock_framerate);
    #1;
  endtask

  // from LOAD: walk through FALL and LOCK into CHECK with the given board status
  task automatic run_to_check(input logic [19:0] lines, input logic ovf);
    completed_lines = lines;
    overflow = ovf;
    fall_tick = 1'b1;
    step();
    filled_under = 1'b1;
    step();
    filled_under = 1'b0;
    step();
    fall_tick = 1'b0;
    checks++;
    if (outs !== V_ZERO) begin
      failures++;
      $display("FAIL check_state_quiet actual=%h required=%h", outs, V_ZERO);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++;
    if (outs !== V_ZERO) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=%h", outs, V_ZERO);
    end
    resetn = 1'b1;
    fall_tick = 1'b1;
    step();
    fall_tick = 1'b0;
    checks++;
    if (outs !== V_ZERO) begin
      failures++;
      $display("FAIL idle_holds actual=%h required=%h", outs, V_ZERO);
    end
  endtask

  task automatic test_decoder();
    logic [35:0] exp_c;
    x = 4'd4; y = 5'd19; block_type = 3'd2; rotation = 2'd1;
    #1;
    checks++;
    if (cells !== {4'd4, 5'd19, 4'd4, 5'd20, 4'd4, 5'd18, 4'd5, 5'd19}) begin
      failures++;
      $display("FAIL decode_t_rot1 actual=%h", cells);
    end
    x = 4'd0; y = 5'd5; block_type = 3'd0; rotation = 2'd0;
    #1;
    checks++;
    if (x2 !== 4'd15) begin
      failures++;
      $display("FAIL decode_i_wrap actual=%0d required=15", x2);
    end
    for (int i = 0; i < 300; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 5'($urandom_range(0, 31));
      block_type = 3'($urandom_range(0, 7));
      rotation = 2'($urandom_range(0, 3));
      #1;
      exp_c = ref_cells(int'(x), int'(y), int'(block_type), int'(rotation));
      checks++;
      if (cells !== exp_c) begin
        failures++;
        $display("FAIL decode_rand type=%0d rot=%0d actual=%h required=%h",
                 block_type, rotation, cells, exp_c);
      end
    end
  endtask

  task automatic test_encoder();
    int e;
    completed_lines = 20'h00A00;
    #1;
    checks++;
    if (cleared_index !== 5'd9) begin
      failures++;
      $display("FAIL enc_a00 actual=%0d required=9", cleared_index);
    end
    completed_lines = 20'h0;
    #1;
    checks++;
    if (cleared_index !== 5'd31) begin
      failures++;
      $display("FAIL enc_zero actual=%0d required=31", cleared_index);
    end
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) completed_lines = 20'(1) << $urandom_range(0, 19);
      else            completed_lines = 20'($urandom) & 20'($urandom);
      #1;
      e = ref_lowest(completed_lines);
      checks++;
      if (int'(cleared_index) != e) begin
        failures++;
        $display("FAIL enc_rand lines=%h actual=%0d required=%0d", completed_lines, cleared_index, e);
      end
    end
    completed_lines = '0;
  endtask

  task automatic test_drop_sequence();
    start_game = 1'b1;
    step();
    checks++;
    if (outs !== V_LOAD) begin failures++; $display("FAIL seq_load actual=%h required=%h", outs, V_LOAD); end
    step();
    start_game = 1'b0;
    checks++;
    if (outs !== V_LOAD) begin failures++; $display("FAIL seq_load_hold actual=%h required=%h", outs, V_LOAD); end
    fall_tick = 1'b1;
    step();
    checks++;
    if (outs !== V_DROP) begin failures++; $display("FAIL seq_drop actual=%h required=%h", outs, V_DROP); end
    step();
    checks++;
    if (outs !== V_DROP) begin failures++; $display("FAIL seq_drop_hold actual=%h required=%h", outs, V_DROP); end
    filled_under = 1'b1;
    step();
    filled_under = 1'b0;
    checks++;
    if (outs !== V_LOCK) begin failures++; $display("FAIL seq_lock actual=%h required=%h", outs, V_LOCK); end
    step();
    fall_tick = 1'b0;
    checks++;
    if (outs !== V_ZERO) begin failures++; $display("FAIL seq_check actual=%h required=%h", outs, V_ZERO); end
    step();
    checks++;
    if (outs !== V_LOAD) begin failures++; $display("FAIL seq_reload actual=%h required=%h", outs, V_LOAD); end
  endtask

  task automatic test_clear();
    int n, frames, shifts, adds, mult_seen, exp_frames, exp_adds, exp_mult;
    bit done;
    logic [19:0] lines;
    for (int it = 0; it < 10; it++) begin
      n = (it < 3) ? it : $urandom_range(1, 6);
      lines = '0;
      while ($countones(lines) < n) lines[$urandom_range(0, 19)] = 1'b1;
      run_to_check(lines, 1'b0);
      frames = 0; shifts = 0; adds = 0; mult_seen = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        fall_tick = 1'($urandom_range(0, 1));
        step();
        frames++;
        if (shift_down) begin
          shifts++;
          completed_lines = completed_lines & (completed_lines - 20'd1);
        end
        if (add_score) begin
          adds++;
          mult_seen = int'(score_multiplier);
        end else begin
          checks++;
          if (score_multiplier !== 3'd0) begin
            failures++;
            $display("FAIL mult_idle actual=%0d required=0", score_multiplier);
          end
        end
        if (load_block) done = 1;
      end
      fall_tick = 1'b0;
      exp_frames = (n == 0) ? 1 : 2 * n + 2;
      exp_adds   = (n == 0) ? 0 : 1;
      exp_mult   = (n > 4) ? 4 : n;
      checks++;
      if (!done) begin failures++; $display("FAIL clear_timeout n=%0d actual=0 required=1", n); end
      checks++;
      if (shifts != n) begin failures++; $display("FAIL clear_shifts actual=%0d required=%0d", shifts, n); end
      checks++;
      if (adds != exp_adds) begin failures++; $display("FAIL clear_adds actual=%0d required=%0d", adds, exp_adds); end
      checks++;
      if (mult_seen != exp_mult) begin failures++; $display("FAIL clear_mult actual=%0d required=%0d", mult_seen, exp_mult); end
      checks++;
      if (frames != exp_frames) begin failures++; $display("FAIL clear_frames actual=%0d required=%0d", frames, exp_frames); end
    end
  endtask

  task automatic test_overflow();
    run_to_check(20'h00003, 1'b1);
    for (int c = 0; c < 6; c++) begin
      fall_tick = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (outs !== V_OVER) begin
        failures++;
        $display("FAIL overflow_hold cycle=%0d actual=%h required=%h", c, outs, V_OVER);
      end
    end
    fall_tick = 1'b0;
`ifndef TETROMINO_RESTART_EN
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    checks++;
    if (outs !== V_OVER) begin failures++; $display("FAIL overflow_start_ignored actual=%h required=%h", outs, V_OVER); end
`endif
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    overflow = 1'b0;
    completed_lines = '0;
    checks++;
    if (outs !== V_ZERO) begin failures++; $display("FAIL overflow_reset actual=%h required=%h", outs, V_ZERO); end
    step();
    checks++;
    if (outs !== V_ZERO) begin failures++; $display("FAIL overflow_idle actual=%h required=%h", outs, V_ZERO); end
  endtask

  task automatic test_mid_clear_reset();
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    run_to_check(20'h00111, 1'b0);
    step();
    checks++;
    if (outs !== V_SHIFT) begin failures++; $display("FAIL mid_clear_enter actual=%h required=%h", outs, V_SHIFT); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    completed_lines = '0;
    checks++;
    if (outs !== V_ZERO) begin failures++; $display("FAIL mid_clear_reset actual=%h required=%h", outs, V_ZERO); end
    step();
    checks++;
    if (outs !== V_ZERO) begin failures++; $display("FAIL mid_clear_idle actual=%h required=%h", outs, V_ZERO); end
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    checks++;
    if (outs !== V_LOAD) begin failures++; $display("FAIL mid_clear_restart actual=%h required=%h", outs, V_LOAD); end
  endtask

  initial begin
    test_reset();
    test_decoder();
    test_encoder();
    test_drop_sequence();
    test_clear();
    test_overflow();
    test_mid_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
